// File: rtl/sort6.sv
// rtl/sort6.sv - six-input unsigned ascending sorter, 12-comparator network plus one output register
// A set loaded with in_valid appears on n0..n5 (n0 smallest) one cycle later with out_valid.
module sort6 #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] Clac_out0,
  input  logic [W-1:0] Clac_out1,
  input  logic [W-1:0] Clac_out2,
  input  logic [W-1:0] Clac_out3,
  input  logic [W-1:0] Clac_out4,
  input  logic [W-1:0] Clac_out5,
  output logic         out_valid,
  output logic [W-1:0] n0,
  output logic [W-1:0] n1,
  output logic [W-1:0] n2,
  output logic [W-1:0] n3,
  output logic [W-1:0] n4,
  output logic [W-1:0] n5
);

  function automatic logic [W-1:0] min2(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [W-1:0] max2(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  logic [W-1:0] l0 [6];
  logic [W-1:0] l1 [6];
  logic [W-1:0] l2 [6];
  logic [W-1:0] l3 [6];
  logic [W-1:0] l4 [6];
  logic [W-1:0] l5 [6];

  assign l0[0] = Clac_out0;
  assign l0[1] = Clac_out1;
  assign l0[2] = Clac_out2;
  assign l0[3] = Clac_out3;
  assign l0[4] = Clac_out4;
  assign l0[5] = Clac_out5;

  // Level 1: (0,5) (1,3) (2,4)
  assign l1[0] = min2(l0[0], l0[5]);
  assign l1[5] = max2(l0[0], l0[5]);
  assign l1[1] = min2(l0[1], l0[3]);
  assign l1[3] = max2(l0[1], l0[3]);
  assign l1[2] = min2(l0[2], l0[4]);
  assign l1[4] = max2(l0[2], l0[4]);

  // Level 2: (1,2) (3,4)
  assign l2[0] = l1[0];
  assign l2[5] = l1[5];
  assign l2[1] = min2(l1[1], l1[2]);
  assign l2[2] = max2(l1[1], l1[2]);
  assign l2[3] = min2(l1[3], l1[4]);
  assign l2[4] = max2(l1[3], l1[4]);

  // Level 3: (0,3) (2,5)
  assign l3[1] = l2[1];
  assign l3[4] = l2[4];
  assign l3[0] = min2(l2[0], l2[3]);
  assign l3[3] = max2(l2[0], l2[3]);
  assign l3[2] = min2(l2[2], l2[5]);
  assign l3[5] = max2(l2[2], l2[5]);

  // Level 4: (0,1) (2,3) (4,5)
  assign l4[0] = min2(l3[0], l3[1]);
  assign l4[1] = max2(l3[0], l3[1]);
  assign l4[2] = min2(l3[2], l3[3]);
  assign l4[3] = max2(l3[2], l3[3]);
  assign l4[4] = min2(l3[4], l3[5]);
  assign l4[5] = max2(l3[4], l3[5]);

  // Level 5: (1,2) (3,4)
  assign l5[0] = l4[0];
  assign l5[5] = l4[5];
  assign l5[1] = min2(l4[1], l4[2]);
  assign l5[2] = max2(l4[1], l4[2]);
  assign l5[3] = min2(l4[3], l4[4]);
  assign l5[4] = max2(l4[3], l4[4]);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      n0 <= '0;
      n1 <= '0;
      n2 <= '0;
      n3 <= '0;
      n4 <= '0;
      n5 <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        n0 <= l5[0];
        n1 <= l5[1];
        n2 <= l5[2];
        n3 <= l5[3];
        n4 <= l5[4];
        n5 <= l5[5];
      end
    end
  end

endmodule

// File: tb/tb_sort6.sv
// tb/tb_sort6.sv - scoreboard bench for sort6 with a queue-sort reference model
module tb_sort6;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] c0, c1, c2, c3, c4, c5;
  logic         out_valid;
  logic [W-1:0] n0, n1, n2, n3, n4, n5;

  int compared = 0;
  int mismatched = 0;

  logic [6*W-1:0] exp_q[$];
  logic [6*W-1:0] held = '0;
  logic           exp_v = 1'b0;
  logic           was_rst = 1'b0;
  logic           mon_on = 1'b0;

  sort6 #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .Clac_out0(c0), .Clac_out1(c1), .Clac_out2(c2),
    .Clac_out3(c3), .Clac_out4(c4), .Clac_out5(c5),
    .out_valid(out_valid),
    .n0(n0), .n1(n1), .n2(n2), .n3(n3), .n4(n4), .n5(n5)
  );

  always #5 clk = ~clk;

  // Reference: sort the six values as plain integers; slot 0 sits in the top bits.
  function automatic logic [6*W-1:0] ref_sort(input logic [6*W-1:0] raw);
    int q[$];
    logic [6*W-1:0] res;
    for (int i = 0; i < 6; i++) q.push_back(int'(raw[(5-i)*W +: W]));
    q.sort();
    res = '0;
    for (int i = 0; i < 6; i++) res[(5-i)*W +: W] = W'(q[i]);
    return res;
  endfunction

  always @(posedge clk) begin
    exp_v   <= in_valid && !rst;
    was_rst <= rst;
  end

  always @(negedge clk) begin
    logic [6*W-1:0] got;
    logic [6*W-1:0] e;
    if (mon_on) begin
      got = {n0, n1, n2, n3, n4, n5};
      compared++;
      if (out_valid !== exp_v) begin
        mismatched++;
        $display("FAIL out_valid got %b want %b at %0t", out_valid, exp_v, $time);
      end
      if (out_valid === 1'b1) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_set got %h want none at %0t", got, $time);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            mismatched++;
            $display("FAIL sorted_set got %h want %h at %0t", got, e, $time);
          end
          held = e;
        end
        compared++;
        if (!(n0 <= n1 && n1 <= n2 && n2 <= n3 && n3 <= n4 && n4 <= n5)) begin
          mismatched++;
          $display("FAIL ordering got %0d %0d %0d %0d %0d %0d want ascending", n0, n1, n2, n3, n4, n5);
        end
      end else begin
        if (was_rst) held = '0;
        compared++;
        if (got !== held) begin
          mismatched++;
          $display("FAIL hold got %h want %h at %0t", got, held, $time);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, b, c, d, e, f);
    c0 = a; c1 = b; c2 = c; c3 = d; c4 = e; c5 = f;
    in_valid = 1'b1;
    if (!rst) exp_q.push_back(ref_sort({a, b, c, d, e, f}));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      in_valid = 1'b0;
      c0 = W'($urandom); c1 = W'($urandom); c2 = W'($urandom);
      c3 = W'($urandom); c4 = W'($urandom); c5 = W'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    c0 = 10'd7; c1 = 10'd300; c2 = 10'd2; c3 = 10'd999; c4 = 10'd40; c5 = 10'd11;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    send(10'd32, 10'd19, 10'd1, 10'd25, 10'd95, 10'd1000);
    @(negedge clk);
    compared++;
    if ({n0, n1, n2, n3, n4, n5} !== {10'd1, 10'd19, 10'd25, 10'd32, 10'd95, 10'd1000}) begin
      mismatched++;
      $display("FAIL basic_const got %0d %0d %0d %0d %0d %0d want 1 19 25 32 95 1000", n0, n1, n2, n3, n4, n5);
    end
    idle(1);

    send(10'd50, 10'd677, 10'd190, 10'd5, 10'd412, 10'd862);
    send(10'd350, 10'd1000, 10'd611, 10'd31, 10'd210, 10'd801);
    idle(1);

    send(10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
    send(10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023);
    send(10'd1023, 10'd0, 10'd1023, 10'd0, 10'd512, 10'd512);
    send(10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6);
    send(10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1);
    idle(1);

    rst = 1'b1;
    send(10'd9, 10'd8, 10'd7, 10'd6, 10'd5, 10'd4);
    rst = 1'b0;
    idle(1);
    send(10'd600, 10'd3, 10'd3, 10'd888, 10'd17, 10'd600);
    idle(1);

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] r [6];
      for (int j = 0; j < 6; j++) r[j] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) != 0) send(r[0], r[1], r[2], r[3], r[4], r[5]);
      else idle(1);
      rst = 1'b0;
    end

    idle(3);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sort6.md
Name: sort6

Overview:
- Registered six-input, 10-bit unsigned sorter used by the SMC datapath.
- Takes six calculator results (Clac_out0..Clac_out5) and presents them in ascending order on n0..n5, with n0 the smallest and n5 the largest.
- Combinational sorting network followed by one output register stage, with a valid strobe.
- Fully pipelined: accepts one new set every clock.

Parameters:
- W, 10, data width of every input and output value (unsigned).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  Clac_out0..5 carry a valid set this cycle.
- Clac_out0  input  W  unsorted value 0.
- Clac_out1  input  W  unsorted value 1.
- Clac_out2  input  W  unsorted value 2.
- Clac_out3  input  W  unsorted value 3.
- Clac_out4  input  W  unsorted value 4.
- Clac_out5  input  W  unsorted value 5.
- out_valid  output  1  n0..n5 hold a freshly sorted set this cycle.
- n0  output  W  smallest value.
- n1  output  W  2nd smallest.
- n2  output  W  3rd smallest.
- n3  output  W  3rd largest.
- n4  output  W  2nd largest.
- n5  output  W  largest value.

Behaviour:
- Reset: on a rising edge with rst=1, n0..n5 <= 0 and out_valid <= 0. rst overrides a simultaneous in_valid; that set is discarded.
- Comparison: unsigned magnitude over the full W bits. No signed interpretation, no saturation, no width change; outputs are an exact permutation of the inputs.
- Sort network: fixed compare-exchange network of 12 comparators, 5 levels (optimal 6-input network), built purely combinationally from Clac_out0..5. Any correct 6-input network is acceptable, provided the combinational depth fits in one cycle.
- Latency: 1 cycle. If in_valid=1 at edge k (rst=0), then from edge k onward until the next load:
  - n0..n5 show the sorted set;
  - out_valid=1 for exactly the cycle following edge k.
- Throughput: back-to-back in_valid accepted every cycle. out_valid then stays high continuously, and each cycle's outputs correspond to the previous cycle's inputs.
- Idle: in_valid=0 (rst=0) -> n0..n5 hold their last value; out_valid <= 0.
- Inputs are sampled only on edges where in_valid=1. Changes to Clac_out* while in_valid=0 have no effect.
- Ties: equal values occupy adjacent output slots. Because equal values are indistinguishable, source order is irrelevant.
- Invariant: whenever out_valid=1, n0<=n1<=n2<=n3<=n4<=n5, and the multiset {n0..n5} equals the input multiset sampled one edge earlier.
- No internal state beyond the output register and out_valid flop. No FSM.

Test Plan:
- Reset check: assert rst 2 cycles with in_valid=1 and arbitrary inputs -> n0..n5=0 and out_valid=0 throughout. Deassert rst -> outputs unchanged until the first in_valid.
- Basic set, in_valid=1 for one cycle: 32,19,1,25,95,1000 -> next cycle out_valid=1 with n0..n5 = 1,19,25,32,95,1000. Following idle cycle: out_valid=0, values held.
- Back-to-back sets on consecutive cycles:
  - 50,677,190,5,412,862 -> 5,50,190,412,677,862;
  - then 350,1000,611,31,210,801 -> 31,210,350,611,801,1000;
  - out_valid high for both consecutive result cycles.
- Boundaries:
  - all inputs 0 -> all outputs 0;
  - all inputs 1023 -> all outputs 1023;
  - input 1023,0,1023,0,512,512 -> 0,0,512,512,1023,1023.
- Already-sorted and reverse-sorted inputs:
  - 1,2,3,4,5,6 -> 1,2,3,4,5,6;
  - 6,5,4,3,2,1 -> 1,2,3,4,5,6.
- Reset mid-stream: in_valid=1 with 9,8,7,6,5,4 on the same edge as rst=1 -> outputs 0 and out_valid=0. The next in_valid with rst=0 yields a correct sort after 1 cycle.
- Randomized: 1000 random sets, checked against a reference sort and the invariant above.
